blob_box_overlay: RTL and testbench
===================================

Name: blob_box_overlay

Overview:
Downstream consumer of the blob segmentation stage. Accepts the per-frame list of blob bounding boxes over a valid/ready stream and holds them in a double-buffered register bank. On the display raster it draws each committed box outline over the incoming video and produces the final 24-bit pixel for the HDMI/VGA output path. Boxes are committed to display only at a frame boundary, so the displayed frame never shows a half-updated box set.

Parameters:
H_IMG_RES, 640, active pixels per line
V_IMG_RES, 480, active lines per frame
MAX_OBJ_NUM, 15, box slots; B_BITS = ceil_log2(MAX_OBJ_NUM)
THICK, 2, outline thickness in pixels, 1..8
BOX_COLOR, 24'hFF0000, outline RGB

Ports:
app_clk  in  1  single clock, equal to the video clock
app_rst  in  1  reset, asynchronous, active-high
box_valid  in  1  box descriptor present
box_ready  out  1  descriptor accepted when box_valid && box_ready
box_idx  in  B_BITS  slot number, 1..MAX_OBJ_NUM
box_top  in  11  box top line
box_bottom  in  11  box bottom line
box_left  in  11  box left pixel
box_right  in  11  box right pixel
box_last  in  1  marks the final descriptor of the frame's list
vid_active_pix  in  1  raster is in the active area
vid_hpos  in  11  raster column
vid_vpos  in  11  raster line
vid_data_in  in  24  underlying video pixel
vid_data_out  out  24  composited pixel
box_count  out  B_BITS+1  number of valid boxes in the displayed bank
swap_pulse  out  1  one-cycle pulse when the shadow bank is committed

Behaviour:
- Reset values: vid_data_out=0, box_count=0, swap_pulse=0, box_ready=1, loader state IDLE, both banks all slots invalid.
- Banks: shadow bank and display bank. Each slot holds top, bottom, left, right (11b each) and a valid bit.
- Loader FSM, states IDLE, LOAD, PENDING:
  - IDLE -> LOAD on the first accepted descriptor.
  - LOAD -> PENDING on acceptance of a descriptor with box_last=1.
  - PENDING -> IDLE at a frame boundary.
  - A box_last descriptor accepted in IDLE goes directly to PENDING.
  - box_ready=1 in IDLE and LOAD, 0 in PENDING.
- Descriptor write: slot box_idx-1 of the shadow bank takes the coordinates.
  - valid = (top<=bottom) && (left<=right) && (bottom<V_IMG_RES) && (right<H_IMG_RES).
  - box_idx=0 or box_idx>MAX_OBJ_NUM: the descriptor is accepted and discarded, but box_last on it still takes effect.
  - Repeated box_idx in one list: the last write wins.
- Frame boundary is the cycle with vid_hpos==0 && vid_vpos==V_IMG_RES (the first blanking line). When the FSM is in PENDING at that cycle:
  - display bank <= shadow bank;
  - shadow valid bits are cleared;
  - box_count <= popcount of the committed valid bits;
  - swap_pulse=1 for exactly that cycle.
  - box_last accepted in the same cycle as a boundary: PENDING starts that cycle, and the swap happens at the next boundary.
  - With no PENDING at a boundary, the display bank is kept, so an unchanged list persists across frames.
- Render pipeline, 2-cycle latency from inputs to vid_data_out:
  - Stage 1 registers vid_data_in, vid_active_pix and a per-slot edge hit.
  - A slot hits when valid && left<=hpos<=right && top<=vpos<=bottom && (hpos-left<THICK || right-hpos<THICK || vpos-top<THICK || bottom-vpos<THICK).
  - Subtractions are 11-bit and are used only inside the box, so they never underflow.
  - Stage 2 output: !active -> 0; else any hit -> BOX_COLOR; else the registered vid_data_in.
  - Overlapping boxes use the same color, so no priority is needed.
- Boxes with width or height below 2*THICK render as solid rectangles.
- app_rst asserted mid-list or mid-frame clears both banks immediately. The output returns to pass-through after 2 cycles of deassertion.

Optional Feature:
BOX_TINT_EN
- Defined: pixels inside a valid box but not on its outline output ((vid_data_in>>1)&24'h7F7F7F) + ((BOX_COLOR>>1)&24'h7F7F7F), a per-channel 50% blend.
- Stage 2 also needs an inside flag from stage 1; latency stays 2 cycles.
- Undefined: interior pixels pass vid_data_in unchanged, and no inside logic is synthesized.

Test Plan:
1. Reset, drive vid_data_in=24'h123456 over an active frame with no boxes -> vid_data_out=24'h123456 two cycles later; box_count=0; box_ready=1.
2. Send idx=1, top=10, bottom=20, left=100, right=110, box_last=1, then cross the boundary -> swap_pulse for one cycle, box_count=1.
   - Next frame: (100,15) and (109,10) show FF0000; (105,15) passes through; (111,15) passes through.
3. In PENDING, hold box_valid=1 -> box_ready=0 until the boundary, then 1 the cycle after swap_pulse.
4. Send idx=2 with top=30, bottom=25 and idx=0, then box_last -> both accepted, box_count=0 after swap, no overlay drawn.
5. Load 3 boxes, assert app_rst mid-frame -> vid_data_out=0 immediately, box_count=0, pass-through restored after 2 cycles.
6. With BOX_TINT_EN, box 1 from scenario 2 and in=24'h00FF00 -> (105,15) outputs 24'h7F7F00; the outline still outputs FF0000.

Source files
------------

// File: rtl/blob_box_overlay.sv
// Double-buffered bounding-box bank with a 2-stage outline compositor for the video output path.
// Build option: define BOX_TINT_EN to blend box interiors 50% toward BOX_COLOR.
module blob_box_overlay #(
    parameter int          H_IMG_RES   = 640,
    parameter int          V_IMG_RES   = 480,
    parameter int          MAX_OBJ_NUM = 15,
    parameter int          THICK       = 2,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
    localparam int         B_BITS      = $clog2(MAX_OBJ_NUM),
    localparam int         CNT_W       = B_BITS + 1
) (
    input  logic              app_clk,
    input  logic              app_rst,
    input  logic              box_valid,
    output logic              box_ready,
    input  logic [B_BITS-1:0] box_idx,
    input  logic [10:0]       box_top,
    input  logic [10:0]       box_bottom,
    input  logic [10:0]       box_left,
    input  logic [10:0]       box_right,
    input  logic              box_last,
    input  logic              vid_active_pix,
    input  logic [10:0]       vid_hpos,
    input  logic [10:0]       vid_vpos,
    input  logic [23:0]       vid_data_in,
    output logic [23:0]       vid_data_out,
    output logic [CNT_W-1:0]  box_count,
    output logic              swap_pulse,
    output logic [1:0]        loader_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam logic [10:0] TH = 11'(THICK);

    state_t           state_q, state_d;
    logic             box_ready_q, box_ready_d;
    logic [CNT_W-1:0] box_count_q;

    logic [10:0]            sh_top_q [MAX_OBJ_NUM];
    logic [10:0]            sh_bot_q [MAX_OBJ_NUM];
    logic [10:0]            sh_lft_q [MAX_OBJ_NUM];
    logic [10:0]            sh_rgt_q [MAX_OBJ_NUM];
    logic [MAX_OBJ_NUM-1:0] sh_vld_q;
    logic [10:0]            dp_top_q [MAX_OBJ_NUM];
    logic [10:0]            dp_bot_q [MAX_OBJ_NUM];
    logic [10:0]            dp_lft_q [MAX_OBJ_NUM];
    logic [10:0]            dp_rgt_q [MAX_OBJ_NUM];
    logic [MAX_OBJ_NUM-1:0] dp_vld_q;

    logic accept, boundary, commit, idx_ok, desc_valid;

    // A descriptor transfers on any rising edge where box_valid && box_ready are both high;
    // the producer must hold all box_* fields stable while box_valid is high and box_ready is low.
    assign accept     = box_valid && box_ready_q;
    assign boundary   = (vid_hpos == 11'd0) && (vid_vpos == 11'(V_IMG_RES));
    assign commit     = boundary && (state_q == ST_PENDING);
    assign idx_ok     = (box_idx != '0) && ({1'b0, box_idx} <= CNT_W'(MAX_OBJ_NUM));
    assign desc_valid = (box_top <= box_bottom) && (box_left <= box_right) &&
                        (box_bottom < 11'(V_IMG_RES)) && (box_right < 11'(H_IMG_RES));

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_OBJ_NUM-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_OBJ_NUM; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = box_last ? ST_PENDING : ST_LOAD;
            ST_LOAD:    if (accept && box_last) state_d = ST_PENDING;
            ST_PENDING: if (boundary) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        box_ready_d = (state_d != ST_PENDING);
    end

    // No descriptor can be accepted in PENDING, so shadow writes and the commit never collide.
    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            state_q     <= ST_IDLE;
            box_ready_q <= 1'b1;
            box_count_q <= '0;
            sh_vld_q    <= '0;
            dp_vld_q    <= '0;
            for (int s = 0; s < MAX_OBJ_NUM; s++) begin
                sh_top_q[s] <= '0;
                sh_bot_q[s] <= '0;
                sh_lft_q[s] <= '0;
                sh_rgt_q[s] <= '0;
                dp_top_q[s] <= '0;
                dp_bot_q[s] <= '0;
                dp_lft_q[s] <= '0;
                dp_rgt_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            box_ready_q <= box_ready_d;
            if (accept && idx_ok) begin
                for (int s = 0; s < MAX_OBJ_NUM; s++) begin
                    if (box_idx == B_BITS'(s + 1)) begin
                        sh_top_q[s] <= box_top;
                        sh_bot_q[s] <= box_bottom;
                        sh_lft_q[s] <= box_left;
                        sh_rgt_q[s] <= box_right;
                        sh_vld_q[s] <= desc_valid;
                    end
                end
            end
            if (commit) begin
                for (int s = 0; s < MAX_OBJ_NUM; s++) begin
                    dp_top_q[s] <= sh_top_q[s];
                    dp_bot_q[s] <= sh_bot_q[s];
                    dp_lft_q[s] <= sh_lft_q[s];
                    dp_rgt_q[s] <= sh_rgt_q[s];
                end
                dp_vld_q    <= sh_vld_q;
                sh_vld_q    <= '0;
                box_count_q <= popcount(sh_vld_q);
            end
        end
    end

    logic [MAX_OBJ_NUM-1:0] inside_d, edge_d;

    // Distances to each side are only meaningful once the pixel is known to be inside the box.
    always_comb begin
        inside_d = '0;
        edge_d   = '0;
        for (int s = 0; s < MAX_OBJ_NUM; s++) begin
            inside_d[s] = dp_vld_q[s] &&
                          (vid_hpos >= dp_lft_q[s]) && (vid_hpos <= dp_rgt_q[s]) &&
                          (vid_vpos >= dp_top_q[s]) && (vid_vpos <= dp_bot_q[s]);
            edge_d[s]   = inside_d[s] &&
                          (((vid_hpos - dp_lft_q[s]) < TH) || ((dp_rgt_q[s] - vid_hpos) < TH) ||
                           ((vid_vpos - dp_top_q[s]) < TH) || ((dp_bot_q[s] - vid_vpos) < TH));
        end
    end

    logic [23:0]            s1_data_q;
    logic                   s1_act_q;
    logic [MAX_OBJ_NUM-1:0] s1_edge_q;
    logic [23:0]            pix_d, pix_q;
`ifdef BOX_TINT_EN
    logic [MAX_OBJ_NUM-1:0] s1_inside_q;
`endif

    always_comb begin
        pix_d = s1_data_q;
`ifdef BOX_TINT_EN
        if (|s1_inside_q) begin
            pix_d = ((s1_data_q >> 1) & 24'h7F7F7F) + ((BOX_COLOR >> 1) & 24'h7F7F7F);
        end
`endif
        if (|s1_edge_q) pix_d = BOX_COLOR;
        if (!s1_act_q)  pix_d = '0;
    end

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            s1_data_q   <= '0;
            s1_act_q    <= 1'b0;
            s1_edge_q   <= '0;
            pix_q       <= '0;
`ifdef BOX_TINT_EN
            s1_inside_q <= '0;
`endif
        end else begin
            s1_data_q   <= vid_data_in;
            s1_act_q    <= vid_active_pix;
            s1_edge_q   <= edge_d;
            pix_q       <= pix_d;
`ifdef BOX_TINT_EN
            s1_inside_q <= inside_d;
`endif
        end
    end

    assign box_ready    = box_ready_q;
    assign box_count    = box_count_q;
    assign swap_pulse   = commit;
    assign vid_data_out = pix_q;
    assign loader_state = state_q;

endmodule

// File: tb/tb_blob_box_overlay.sv
// Directed bench for blob_box_overlay: handshake, frame-boundary commit, outline render, reset.
module tb_blob_box_overlay;

    logic        app_clk, app_rst;
    logic        box_valid, box_ready;
    logic [3:0]  box_idx;
    logic [10:0] box_top, box_bottom, box_left, box_right;
    logic        box_last;
    logic        vid_active_pix;
    logic [10:0] vid_hpos, vid_vpos;
    logic [23:0] vid_data_in, vid_data_out;
    logic [4:0]  box_count;
    logic        swap_pulse;
    logic [1:0]  loader_state;

    int tests = 0;
    int fails = 0;

`ifdef BOX_TINT_EN
    localparam logic [23:0] INTERIOR_GREEN = 24'h7F7F00;
`else
    localparam logic [23:0] INTERIOR_GREEN = 24'h00FF00;
`endif

    blob_box_overlay dut (
        .app_clk        (app_clk),
        .app_rst        (app_rst),
        .box_valid      (box_valid),
        .box_ready      (box_ready),
        .box_idx        (box_idx),
        .box_top        (box_top),
        .box_bottom     (box_bottom),
        .box_left       (box_left),
        .box_right      (box_right),
        .box_last       (box_last),
        .vid_active_pix (vid_active_pix),
        .vid_hpos       (vid_hpos),
        .vid_vpos       (vid_vpos),
        .vid_data_in    (vid_data_in),
        .vid_data_out   (vid_data_out),
        .box_count      (box_count),
        .swap_pulse     (swap_pulse),
        .loader_state   (loader_state)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    task automatic tick();
        @(posedge app_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic act,
                           input logic [23:0] d);
        vid_hpos       = h;
        vid_vpos       = v;
        vid_active_pix = act;
        vid_data_in    = d;
    endtask

    task automatic check_pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                             input logic [23:0] d, input logic [23:0] exp);
        set_pix(h, v, 1'b1, d);
        tick();
        tick();
        check(tag, vid_data_out, exp);
    endtask

    task automatic send_box(input logic [3:0] idx, input logic [10:0] t, input logic [10:0] b,
                            input logic [10:0] l, input logic [10:0] r, input logic last);
        check("ready_before_send", box_ready, 1'b1);
        box_valid  = 1'b1;
        box_idx    = idx;
        box_top    = t;
        box_bottom = b;
        box_left   = l;
        box_right  = r;
        box_last   = last;
        tick();
        box_valid  = 1'b0;
        box_last   = 1'b0;
    endtask

    task automatic cross_boundary(input string tag, input logic exp_swap, input logic [4:0] exp_cnt);
        set_pix(11'd0, 11'd480, 1'b0, 24'h0);
        #1;
        check({tag, "_swap"}, swap_pulse, exp_swap);
        tick();
        check({tag, "_swap_after"}, swap_pulse, 1'b0);
        check({tag, "_count"}, box_count, exp_cnt);
        set_pix(11'd5, 11'd481, 1'b0, 24'h0);
    endtask

    initial begin
        app_rst = 1'b1;
        box_valid = 1'b0; box_idx = '0; box_last = 1'b0;
        box_top = '0; box_bottom = '0; box_left = '0; box_right = '0;
        set_pix(11'd5, 11'd481, 1'b0, 24'h0);
        tick();
        tick();
        check("rst_out", vid_data_out, 24'h0);
        check("rst_count", box_count, 5'd0);
        check("rst_ready", box_ready, 1'b1);
        check("rst_swap", swap_pulse, 1'b0);
        check("rst_state", loader_state, 2'd0);
        app_rst = 1'b0;
        tick();

        // Empty bank: pure pass-through, blanking forces black.
        check_pix("s1_pass", 11'd5, 11'd5, 24'h123456, 24'h123456);
        set_pix(11'd5, 11'd5, 1'b0, 24'h123456);
        tick(); tick();
        check("s1_blank", vid_data_out, 24'h0);
        check("s1_count", box_count, 5'd0);

        // Single box; invisible until the boundary commit.
        send_box(4'd1, 11'd10, 11'd20, 11'd100, 11'd110, 1'b1);
        check("s2_state_pending", loader_state, 2'd2);
        check("s2_ready_pending", box_ready, 1'b0);
        check_pix("s2_precommit", 11'd100, 11'd15, 24'h123456, 24'h123456);
        cross_boundary("s2_commit", 1'b1, 5'd1);
        check("s2_ready_after", box_ready, 1'b1);
        check("s2_state_idle", loader_state, 2'd0);
        check_pix("s2_left_edge", 11'd100, 11'd15, 24'h123456, 24'hFF0000);
        check_pix("s2_top_edge", 11'd109, 11'd10, 24'h123456, 24'hFF0000);
        check_pix("s2_inner_edge", 11'd109, 11'd15, 24'h123456, 24'hFF0000);
        check_pix("s2_interior", 11'd105, 11'd15, 24'h00FF00, INTERIOR_GREEN);
        check_pix("s2_outside", 11'd111, 11'd15, 24'h123456, 24'h123456);
        set_pix(11'd1, 11'd480, 1'b0, 24'h0);
        #1;
        check("s2_not_boundary", swap_pulse, 1'b0);
        cross_boundary("s2_persist", 1'b0, 5'd1);
        check_pix("s2_persist_edge", 11'd110, 11'd20, 24'h123456, 24'hFF0000);

        // Backpressure while PENDING; the held descriptor transfers after the commit.
        send_box(4'd3, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1);
        box_valid = 1'b1; box_idx = 4'd2; box_last = 1'b0;
        box_top = 11'd30; box_bottom = 11'd25; box_left = 11'd5; box_right = 11'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_ready_held", box_ready, 1'b0);
        end
        set_pix(11'd0, 11'd480, 1'b0, 24'h0);
        #1;
        check("s3_swap", swap_pulse, 1'b1);
        check("s3_ready_at_swap", box_ready, 1'b0);
        tick();
        check("s3_ready_after", box_ready, 1'b1);
        check("s3_count", box_count, 5'd1);
        check("s3_state_idle", loader_state, 2'd0);
        set_pix(11'd5, 11'd481, 1'b0, 24'h0);
        tick();
        box_valid = 1'b0;
        check("s3_state_load", loader_state, 2'd1);
        check_pix("s3_dot", 11'd0, 11'd0, 24'h123456, 24'hFF0000);
        check_pix("s3_beside_dot", 11'd1, 11'd0, 24'h123456, 24'h123456);
        check_pix("s3_old_box_gone", 11'd100, 11'd15, 24'h123456, 24'h123456);

        // Invalid geometry, out-of-range right edge and idx 0 all accepted but never drawn.
        send_box(4'd5, 11'd10, 11'd20, 11'd600, 11'd640, 1'b0);
        send_box(4'd0, 11'd10, 11'd20, 11'd100, 11'd110, 1'b1);
        check("s4_state_pending", loader_state, 2'd2);
        cross_boundary("s4_commit", 1'b1, 5'd0);
        check_pix("s4_inverted", 11'd5, 11'd25, 24'h123456, 24'h123456);
        check_pix("s4_idx0", 11'd100, 11'd10, 24'h123456, 24'h123456);
        check_pix("s4_right640", 11'd600, 11'd10, 24'h123456, 24'h123456);
        check_pix("s4_dot_gone", 11'd0, 11'd0, 24'h123456, 24'h123456);

        // Three boxes, repeated idx, box touching the last pixel; then reset mid-frame.
        send_box(4'd1, 11'd10, 11'd20, 11'd100, 11'd110, 1'b0);
        send_box(4'd1, 11'd10, 11'd20, 11'd300, 11'd310, 1'b0);
        send_box(4'd2, 11'd470, 11'd479, 11'd630, 11'd639, 1'b0);
        send_box(4'd3, 11'd0, 11'd5, 11'd0, 11'd5, 1'b1);
        cross_boundary("s5_commit", 1'b1, 5'd3);
        check_pix("s5_last_wins", 11'd300, 11'd15, 24'h123456, 24'hFF0000);
        check_pix("s5_overwritten", 11'd100, 11'd15, 24'h123456, 24'h123456);
        check_pix("s5_corner", 11'd639, 11'd479, 24'h123456, 24'hFF0000);
        check_pix("s5_interior", 11'd635, 11'd475, 24'h00FF00, INTERIOR_GREEN);
        check_pix("s5_box3", 11'd5, 11'd2, 24'h123456, 24'hFF0000);
        set_pix(11'd300, 11'd15, 1'b1, 24'h123456);
        tick(); tick();
        check("s5_pre_reset", vid_data_out, 24'hFF0000);
        app_rst = 1'b1;
        #1;
        check("s5_rst_out", vid_data_out, 24'h0);
        check("s5_rst_count", box_count, 5'd0);
        check("s5_rst_ready", box_ready, 1'b1);
        tick();
        app_rst = 1'b0;
        tick(); tick();
        check("s5_passthru", vid_data_out, 24'h123456);
        cross_boundary("s5_no_commit", 1'b0, 5'd0);
        check_pix("s5_bank_cleared", 11'd639, 11'd479, 24'h123456, 24'h123456);

        // box_last accepted on the boundary cycle commits at the following boundary.
        set_pix(11'd0, 11'd480, 1'b0, 24'h0);
        box_valid = 1'b1; box_idx = 4'd1; box_last = 1'b1;
        box_top = 11'd10; box_bottom = 11'd20; box_left = 11'd100; box_right = 11'd110;
        #1;
        check("s6_swap_same_cycle", swap_pulse, 1'b0);
        tick();
        box_valid = 1'b0; box_last = 1'b0;
        check("s6_state_pending", loader_state, 2'd2);
        check("s6_count_kept", box_count, 5'd0);
        set_pix(11'd5, 11'd481, 1'b0, 24'h0);
        tick();
        cross_boundary("s6_commit", 1'b1, 5'd1);
        check_pix("s6_edge", 11'd100, 11'd15, 24'h123456, 24'hFF0000);
        check_pix("s6_interior", 11'd105, 11'd15, 24'h00FF00, INTERIOR_GREEN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
